fifo8_sync: RTL and testbench
=============================

Name: fifo8_sync

Overview:
- 8-entry synchronous FIFO with valid/ready handshakes on both sides.
- Buffers WIDTH-bit words between a producer stage and a consumer stage in the mini-project datapath.
- Built from the library primitives:
  - demux8 decodes the write slot.
  - mux8 selects the read slot, one instance per data bit.
  - Per-bit flops hold the storage.
- First-word-fall-through: the head word is presented combinationally whenever the FIFO is non-empty.

Parameters:
- WIDTH, 16, data word width in bits (1..32).

Ports:
- clk  input  1  rising-edge clock for all state.
- reset_  input  1  asynchronous, active-low reset. Assertion clears state immediately; deassertion is sampled synchronously to clk.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  FIFO can accept a word this cycle.
- in_data  input  WIDTH  write data.
- out_valid  output  1  out_data holds the valid head word.
- out_ready  input  1  consumer takes the head word this cycle.
- out_data  output  WIDTH  head word (FWFT).
- count  output  4  occupancy, 0..8.

Behaviour:
- Reset (reset_=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - All 8 storage words = 0.
  - in_ready=1, out_valid=0, out_data=0.
- Outputs are registered or decoded directly from registered state:
  - in_ready = (count != 8).
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr], selected via mux8.
- push = in_valid & in_ready:
  - On the clk edge, mem[wr_ptr] <= in_data.
  - wr_ptr <= wr_ptr+1, wrapping mod 8 (7 -> 0).
  - Only the slot selected by demux8 is written; the other 7 hold.
- pop = out_valid & out_ready:
  - On the clk edge, rd_ptr <= rd_ptr+1, wrapping mod 8.
  - Popping does not clear storage.
- count update:
  - push & !pop: +1.
  - pop & !push: -1.
  - push & pop, or neither: unchanged.
- Latency:
  - A word pushed at edge N is visible on out_data with out_valid=1 from just after edge N when the FIFO was empty.
  - Push-to-head latency is therefore 1 cycle.
- Full (count=8):
  - in_ready=0, so a same-cycle pop does NOT enable a push. There is no full pass-through.
  - The pop proceeds; in_ready rises the next cycle.
- Empty (count=0):
  - out_valid=0 and a same-cycle push does NOT bypass to out_data.
  - The push proceeds; out_valid rises the next cycle.
  - out_data shows mem[rd_ptr], which is stale. Consumers must ignore it while out_valid=0.
- Handshake rules:
  - Words leave in exactly the order they were accepted. No loss, no duplication.
  - in_valid/out_ready may toggle on any cycle. No combinational path exists from in_valid to in_ready or from out_ready to out_valid.
- Reset mid-operation: any queued words are discarded and the state returns to the reset values within the same cycle reset_ falls.
- Illegal attempts:
  - in_valid while full is ignored.
  - out_ready while empty is ignored.
  - No state changes in either case.

Optional Feature:
- Macro: FIFO8_ERR_EN.
- Defined:
  - Adds output ports err_ovf (1) and err_unf (1), both reset to 0.
  - err_ovf is set on the clk edge when in_valid=1 and count=8.
  - err_unf is set on the clk edge when out_ready=1 and count=0.
  - Both are sticky and are cleared only by reset_.
  - Data path behaviour is identical to the undefined case.
- Undefined: these ports and their logic are absent.

Test Plan:
- Reset check: drive reset_=0 mid-cycle, with no clk edge required -> count=0, in_ready=1, out_valid=0, out_data=0.
- Basic ordering: push 0x1111, 0x2222, 0x3333 on consecutive cycles with out_ready=0; then assert out_ready for 3 cycles -> out_data reads 0x1111, 0x2222, 0x3333 in that order; count goes 1, 2, 3, 2, 1, 0.
- Full boundary: push 0x0000..0x0008 (9 attempts) with out_ready=0 -> first 8 accepted, count=8, in_ready=0, and 0x0008 is not stored. Then assert in_valid=1 with data 0x00AA together with out_ready=1 for one cycle -> pop of 0x0000 occurs, push rejected, count=7, in_ready=1 next cycle.
- Wrap-around: 20 cycles of continuous push+pop with count held at 3, data = cycle index -> output sequence is contiguous, count stays 3, pointers wrap 7 -> 0 at least twice.
- Empty boundary: with count=0, push 0x5A5A with out_ready=1 -> no pop that cycle; next cycle out_valid=1, out_data=0x5A5A, and it pops on that cycle.
- Async reset mid-stream: with count=5, pull reset_ low between edges -> count=0 and out_valid=0 immediately. After release, push 0x7777 -> it is the only word output.
- Error flags (with FIFO8_ERR_EN): out_ready=1 while empty -> err_unf=1 after the edge. Fill to 8, then in_valid=1 -> err_ovf=1. Both stay high until reset_=0.

Source files
------------

// File: rtl/fifo8_sync.sv
// fifo8_sync: 8-entry first-word-fall-through FIFO with valid/ready handshakes, built from demux8/mux8 primitives.
// Define FIFO8_ERR_EN to add sticky overflow/underflow flags (err_ovf, err_unf).

module demux8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] out
);
  always_comb begin
    out = 8'd0;
    out[sel] = en;
  end
endmodule

module mux8 (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       out
);
  assign out = in[sel];
endmodule

module fifo8_sync #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef FIFO8_ERR_EN
  output logic             err_ovf,
  output logic             err_unf,
`endif
  output logic [3:0]       count
);

  logic [2:0]       wr_ptr;
  logic [2:0]       rd_ptr;
  logic [3:0]       count_q;
  logic [7:0]       wr_sel;
  logic [WIDTH-1:0] mem [8];
  logic             push;
  logic             pop;

  // Handshake outputs come only from registered occupancy, never from in_valid/out_ready.
  assign in_ready  = (count_q != 4'd8);
  assign out_valid = (count_q != 4'd0);
  assign count     = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  demux8 u_wr_decode (
    .en  (push),
    .sel (wr_ptr),
    .out (wr_sel)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_sel[i]) mem[i] <= in_data;
      end
    end
  end

  // One mux8 per data bit picks the head word out of the storage column.
  for (genvar b = 0; b < WIDTH; b++) begin : g_rd_bit
    logic [7:0] column;
    for (genvar s = 0; s < 8; s++) begin : g_col
      assign column[s] = mem[s][b];
    end
    mux8 u_rd_mux (
      .in  (column),
      .sel (rd_ptr),
      .out (out_data[b])
    );
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr  <= 3'd0;
      rd_ptr  <= 3'd0;
      count_q <= 4'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (pop)  rd_ptr <= rd_ptr + 3'd1;
      if (push && !pop)      count_q <= count_q + 4'd1;
      else if (pop && !push) count_q <= count_q - 4'd1;
    end
  end

`ifdef FIFO8_ERR_EN
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (in_valid && count_q == 4'd8)  err_ovf <= 1'b1;
      if (out_ready && count_q == 4'd0) err_unf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo8_sync.sv
// Directed self-checking bench for fifo8_sync; the flag checks are active when FIFO8_ERR_EN is defined.

module tb_fifo8_sync;

  logic        clk = 1'b0;
  logic        reset_;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  count;
`ifdef FIFO8_ERR_EN
  logic        err_ovf;
  logic        err_unf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo8_sync #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef FIFO8_ERR_EN
    .err_ovf   (err_ovf),
    .err_unf   (err_unf),
`endif
    .count     (count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic ready);
    in_valid  = valid;
    in_data   = data;
    out_ready = ready;
  endtask

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_ = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0);
    tick();

    #3 reset_ = 1'b0;
    #1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    tick();
    #2 reset_ = 1'b1;
    tick();

    applyStimulus(1'b1, 16'h1111, 1'b0); tick();
    checkOutput("ord_count1", 32'(count), 32'd1);
    checkOutput("ord_head_latency", 32'(out_data), 32'h1111);
    checkOutput("ord_valid_latency", 32'(out_valid), 32'd1);
    applyStimulus(1'b1, 16'h2222, 1'b0); tick();
    checkOutput("ord_count2", 32'(count), 32'd2);
    applyStimulus(1'b1, 16'h3333, 1'b0); tick();
    checkOutput("ord_count3", 32'(count), 32'd3);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("ord_out0", 32'(out_data), 32'h1111); tick();
    checkOutput("ord_count_d2", 32'(count), 32'd2);
    checkOutput("ord_out1", 32'(out_data), 32'h2222); tick();
    checkOutput("ord_count_d1", 32'(count), 32'd1);
    checkOutput("ord_out2", 32'(out_data), 32'h3333); tick();
    checkOutput("ord_count_d0", 32'(count), 32'd0);
    checkOutput("ord_empty_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0);
      tick();
    end
    checkOutput("full_count", 32'(count), 32'd8);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("full_head", 32'(out_data), 32'h0000);
    applyStimulus(1'b1, 16'h00AA, 1'b1); tick();
    checkOutput("full_pop_count", 32'(count), 32'd7);
    checkOutput("full_ready_back", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      checkOutput($sformatf("full_drain%0d", k), 32'(out_data), 32'(k));
      tick();
    end
    checkOutput("full_drain_count", 32'(count), 32'd0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0);
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, 16'(c + 3), 1'b1);
      checkOutput($sformatf("wrap_out%0d", c), 32'(out_data), 32'(c));
      tick();
      checkOutput($sformatf("wrap_count%0d", c), 32'(count), 32'd3);
    end
    applyStimulus(1'b0, 16'h0, 1'b1);
    for (int k = 20; k < 23; k++) begin
      checkOutput($sformatf("wrap_tail%0d", k), 32'(out_data), 32'(k));
      tick();
    end
    checkOutput("wrap_end_count", 32'(count), 32'd0);

    applyStimulus(1'b1, 16'h5A5A, 1'b1); tick();
    checkOutput("empty_no_pop", 32'(count), 32'd1);
    checkOutput("empty_valid", 32'(out_valid), 32'd1);
    checkOutput("empty_data", 32'(out_data), 32'h5A5A);
    applyStimulus(1'b0, 16'h0, 1'b1); tick();
    checkOutput("empty_popped", 32'(count), 32'd0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'h4000 + 16'(i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("arst_pre_count", 32'(count), 32'd5);
    #3 reset_ = 1'b0;
    #1;
    checkOutput("arst_count", 32'(count), 32'd0);
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_data", 32'(out_data), 32'd0);
    tick();
    #2 reset_ = 1'b1;
    tick();
    applyStimulus(1'b1, 16'h7777, 1'b0); tick();
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("arst_only_count", 32'(count), 32'd1);
    checkOutput("arst_only_data", 32'(out_data), 32'h7777);
    tick();
    checkOutput("arst_drained", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0);

`ifdef FIFO8_ERR_EN
    #3 reset_ = 1'b0;
    #3 reset_ = 1'b1;
    tick();
    checkOutput("err_unf_clear", 32'(err_unf), 32'd0);
    checkOutput("err_ovf_clear", 32'(err_ovf), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1); tick();
    checkOutput("err_unf_set", 32'(err_unf), 32'd1);
    checkOutput("err_unf_count", 32'(count), 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0);
      tick();
    end
    checkOutput("err_ovf_before", 32'(err_ovf), 32'd0);
    applyStimulus(1'b1, 16'hBEEF, 1'b0); tick();
    checkOutput("err_ovf_set", 32'(err_ovf), 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b0); tick(); tick();
    checkOutput("err_ovf_sticky", 32'(err_ovf), 32'd1);
    checkOutput("err_unf_sticky", 32'(err_unf), 32'd1);
    #3 reset_ = 1'b0;
    #1;
    checkOutput("err_ovf_rst", 32'(err_ovf), 32'd0);
    checkOutput("err_unf_rst", 32'(err_unf), 32'd0);
    #2 reset_ = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
